// File: rtl/pie_rx_pkg.sv
// Shared types and CRC-5 helpers for the pulse-interval frame receiver and its
// future transmit counterpart.
package pie_rx_pkg;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    PAYLOAD = 2'd1,
    CHECK   = 2'd2
  } rx_state_t;

  localparam int         CRC_LEN   = 5;
  localparam logic [4:0] CRC5_POLY = 5'h05;
  localparam logic [4:0] CRC5_INIT = 5'h1F;

  // One serial step of the x^5+x^2+1 CRC, MSB-first, no final XOR.
  function automatic logic [4:0] crc5_next(input logic [4:0] crc, input logic data_bit);
    logic fb;
    fb = crc[4] ^ data_bit;
    return {crc[3:0], 1'b0} ^ (fb ? CRC5_POLY : 5'h00);
  endfunction

endpackage

// File: rtl/pie_crc5.sv
// Serial CRC-5 accumulator. Clear reloads the seed; enable folds in one bit.
module pie_crc5
  import pie_rx_pkg::*;
(
  input  logic               sclk_3mhz,
  input  logic               reset_n,
  input  logic               clear,
  input  logic               enable,
  input  logic               bit_in,
  output logic [CRC_LEN-1:0] crc
);

  // Seed on reset or clear, otherwise advance once per enabled bit.
  always_ff @(posedge sclk_3mhz) begin
    if (!reset_n) begin
      crc <= CRC5_INIT;
    end else if (clear) begin
      crc <= CRC5_INIT;
    end else if (enable) begin
      crc <= crc5_next(crc, bit_in);
    end
  end

endmodule

// File: rtl/pie_frame_rx.sv
// Frame receiver behind the ZCD pulse-interval decoder: hunts for the sync
// word, collects a fixed payload, verifies a trailing CRC-5 and hands good
// frames to a single-entry valid/ready slot with saturating frame counters.
module pie_frame_rx
  import pie_rx_pkg::*;
#(
  parameter int                  SYNC_LEN     = 4,
  parameter logic [SYNC_LEN-1:0] SYNC_WORD    = 4'b0101,
  parameter int                  PAYLOAD_BITS = 16,
  parameter int                  TIMEOUT_CYC  = 48
) (
  input  logic                    sclk_3mhz,
  input  logic                    reset_n,
  input  logic                    sym_valid,
  input  logic                    sym_bit,
  input  logic                    sym_err,
  output logic [PAYLOAD_BITS-1:0] frame_data,
  output logic                    frame_valid,
  input  logic                    frame_ready,
  output logic                    crc_err,
  output logic                    timeout_err,
  output logic                    overflow,
  output logic                    busy,
  output logic [7:0]              frame_ok_count,
  output logic [7:0]              frame_err_count
);

  localparam int FILL_W = $clog2(SYNC_LEN + 1);
  localparam int BIT_W  = $clog2(PAYLOAD_BITS);
  localparam int IDLE_W = $clog2(TIMEOUT_CYC);
  localparam int CHK_W  = $clog2(CRC_LEN);

  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(SYNC_LEN);
  localparam logic [FILL_W-1:0] FILL_ONE  = FILL_W'(1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(PAYLOAD_BITS - 1);
  localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYC - 1);
  localparam logic [IDLE_W-1:0] IDLE_ONE  = IDLE_W'(1);
  localparam logic [CHK_W-1:0]  CHK_LAST  = CHK_W'(CRC_LEN - 1);
  localparam logic [CHK_W-1:0]  CHK_ONE   = CHK_W'(1);

  rx_state_t                state;
  logic [SYNC_LEN-1:0]      sync_sr;
  logic [SYNC_LEN-1:0]      sync_next;
  logic [FILL_W-1:0]        fill_cnt;
  logic [FILL_W-1:0]        fill_next;
  logic                     sync_match;
  logic [BIT_W-1:0]         bit_cnt;
  logic [PAYLOAD_BITS-1:0]  payload_sr;
  logic [CHK_W-1:0]         chk_cnt;
  logic [CRC_LEN-2:0]       crc_rx_sr;
  logic [IDLE_W-1:0]        idle_cnt;
  logic                     sym_take;
  logic                     crc_clear;
  logic                     crc_enable;
  logic [CRC_LEN-1:0]       crc_value;
  logic                     crc_pass;
  logic                     slot_free;

  // A symbol flagged as undecodable is never used as data.
  assign sym_take   = sym_valid && !sym_err;
  assign sync_next  = {sync_sr[SYNC_LEN-2:0], sym_bit};
  assign fill_next  = (fill_cnt == FILL_FULL) ? fill_cnt : fill_cnt + FILL_ONE;
  assign sync_match = (fill_next == FILL_FULL) && (sync_next == SYNC_WORD);
  assign crc_clear  = (state == HUNT) && sym_take && sync_match;
  assign crc_enable = (state == PAYLOAD) && sym_take;
  assign crc_pass   = ({crc_rx_sr, sym_bit} == crc_value);
  assign slot_free  = !frame_valid || frame_ready;

  pie_crc5 u_crc (
    .sclk_3mhz (sclk_3mhz),
    .reset_n   (reset_n),
    .clear     (crc_clear),
    .enable    (crc_enable),
    .bit_in    (sym_bit),
    .crc       (crc_value)
  );

  // Receive FSM with its datapath, output slot, pulses and counters.
  always_ff @(posedge sclk_3mhz) begin
    if (!reset_n) begin
      state           <= HUNT;
      sync_sr         <= '0;
      fill_cnt        <= '0;
      bit_cnt         <= '0;
      payload_sr      <= '0;
      chk_cnt         <= '0;
      crc_rx_sr       <= '0;
      idle_cnt        <= '0;
      frame_data      <= '0;
      frame_valid     <= 1'b0;
      crc_err         <= 1'b0;
      timeout_err     <= 1'b0;
      overflow        <= 1'b0;
      busy            <= 1'b0;
      frame_ok_count  <= 8'h00;
      frame_err_count <= 8'h00;
    end else begin
      crc_err     <= 1'b0;
      timeout_err <= 1'b0;
      overflow    <= 1'b0;
      if (frame_valid && frame_ready) begin
        frame_valid <= 1'b0;
      end
      case (state)
        HUNT: begin
          idle_cnt <= '0;
          if (sym_err) begin
            sync_sr  <= '0;
            fill_cnt <= '0;
          end else if (sym_valid) begin
            if (sync_match) begin
              state    <= PAYLOAD;
              busy     <= 1'b1;
              bit_cnt  <= '0;
              sync_sr  <= '0;
              fill_cnt <= '0;
            end else begin
              sync_sr  <= sync_next;
              fill_cnt <= fill_next;
            end
          end
        end
        PAYLOAD, CHECK: begin
          if (sym_err) begin
            state    <= HUNT;
            busy     <= 1'b0;
            idle_cnt <= '0;
            if (frame_err_count != 8'hFF) frame_err_count <= frame_err_count + 8'd1;
          end else if (sym_valid) begin
            idle_cnt <= '0;
            if (state == PAYLOAD) begin
              payload_sr <= {payload_sr[PAYLOAD_BITS-2:0], sym_bit};
              if (bit_cnt == BIT_LAST) begin
                state   <= CHECK;
                chk_cnt <= '0;
              end else begin
                bit_cnt <= bit_cnt + BIT_ONE;
              end
            end else begin
              crc_rx_sr <= {crc_rx_sr[CRC_LEN-3:0], sym_bit};
              if (chk_cnt == CHK_LAST) begin
                state <= HUNT;
                busy  <= 1'b0;
                if (crc_pass) begin
                  if (frame_ok_count != 8'hFF) frame_ok_count <= frame_ok_count + 8'd1;
                  if (slot_free) begin
                    frame_data  <= payload_sr;
                    frame_valid <= 1'b1;
                  end else begin
                    overflow <= 1'b1;
                  end
                end else begin
                  crc_err <= 1'b1;
                  if (frame_err_count != 8'hFF) frame_err_count <= frame_err_count + 8'd1;
                end
              end else begin
                chk_cnt <= chk_cnt + CHK_ONE;
              end
            end
          end else if (idle_cnt == IDLE_LAST) begin
            state       <= HUNT;
            busy        <= 1'b0;
            idle_cnt    <= '0;
            timeout_err <= 1'b1;
            if (frame_err_count != 8'hFF) frame_err_count <= frame_err_count + 8'd1;
          end else begin
            idle_cnt <= idle_cnt + IDLE_ONE;
          end
        end
        default: begin
          state <= HUNT;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
